// File: rtl/mac_operand_sequencer_if.sv
// Host-side bus of the MAC operand sequencer: operand write channel, run control and result.
// master = host, slave = sequencer.
interface mac_operand_sequencer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_ai;
  logic [7:0]  wr_xi;
  logic        start;
  logic        busy;
  logic        start_err;
  logic [15:0] result;
  logic        result_valid;

  modport master (
    output wr_valid, wr_ai, wr_xi, start,
    input  wr_ready, busy, start_err, result, result_valid
  );

  modport slave (
    input  wr_valid, wr_ai, wr_xi, start,
    output wr_ready, busy, start_err, result, result_valid
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Buffers up to DEPTH (ai,xi) pairs, streams them into a Product_Sum MAC one per cycle on start,
// flags the final pair as last and captures the MAC sum into a registered result.
module mac_operand_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mac_operand_sequencer_if.slave  host,
  output logic [7:0]              o_mac_ai,
  output logic [7:0]              o_mac_xi,
  output logic                    o_mac_last,
  input  logic [15:0]             i_mac_result
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_CAPTURE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_rd_ptr;
  logic [7:0]       r_ai_mem [2**AW];
  logic [7:0]       r_xi_mem [2**AW];
  logic [7:0]       r_mac_ai;
  logic [7:0]       r_mac_xi;
  logic             r_mac_last;
  logic             r_busy;
  logic             r_start_err;
  logic [15:0]      r_result;
  logic             r_result_valid;

  logic             w_wr_ready;
  logic             w_wr_fire;
  logic [CNT_W-1:0] w_count_eff;
  logic [7:0]       w_first_ai;
  logic [7:0]       w_first_xi;

  assign w_wr_ready  = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH));
  assign w_wr_fire   = host.wr_valid & w_wr_ready;
  assign w_count_eff = r_count + {{(CNT_W-1){1'b0}}, w_wr_fire};

  // A write landing on the same edge as start into an empty buffer is pair 0; bypass the memory.
  assign w_first_ai  = (r_count == '0) ? host.wr_ai : r_ai_mem[0];
  assign w_first_xi  = (r_count == '0) ? host.wr_xi : r_xi_mem[0];

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_ai_mem[r_count[AW-1:0]] <= host.wr_ai;
      r_xi_mem[r_count[AW-1:0]] <= host.wr_xi;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_rd_ptr       <= '0;
      r_mac_ai       <= '0;
      r_mac_xi       <= '0;
      r_mac_last     <= 1'b0;
      r_busy         <= 1'b0;
      r_start_err    <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_start_err    <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_count <= w_count_eff;
          if (host.start) begin
            if (w_count_eff != '0) begin
              r_state    <= S_STREAM;
              r_busy     <= 1'b1;
              r_mac_ai   <= w_first_ai;
              r_mac_xi   <= w_first_xi;
              r_mac_last <= (w_count_eff == CNT_W'(1));
              r_rd_ptr   <= CNT_W'(1);
            end else begin
              r_start_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (r_mac_last) begin
            // Idle cycles must feed zeros so the accumulator only ever adds zero between runs.
            r_state    <= S_CAPTURE;
            r_mac_ai   <= '0;
            r_mac_xi   <= '0;
            r_mac_last <= 1'b0;
          end else begin
            r_mac_ai   <= r_ai_mem[r_rd_ptr[AW-1:0]];
            r_mac_xi   <= r_xi_mem[r_rd_ptr[AW-1:0]];
            r_mac_last <= (r_rd_ptr == r_count - CNT_W'(1));
            r_rd_ptr   <= r_rd_ptr + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          r_result       <= i_mac_result;
          r_result_valid <= 1'b1;
          r_count        <= '0;
          r_rd_ptr       <= '0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign host.wr_ready     = w_wr_ready;
  assign host.busy         = r_busy;
  assign host.start_err    = r_start_err;
  assign host.result       = r_result;
  assign host.result_valid = r_result_valid;

  assign o_mac_ai   = r_mac_ai;
  assign o_mac_xi   = r_mac_xi;
  assign o_mac_last = r_mac_last;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural Product_Sum accumulator
// sharing clk/reset; every expected result is a hand-computed constant.
module tb_mac_operand_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  mac_ai;
  logic [7:0]  mac_xi;
  logic        mac_last;
  logic [15:0] mac_result;

  mac_operand_sequencer_if u_if ();

  mac_operand_sequencer #(
    .DEPTH (8),
    .CNT_W (4)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .host         (u_if),
    .o_mac_ai     (mac_ai),
    .o_mac_xi     (mac_xi),
    .o_mac_last   (mac_last),
    .i_mac_result (mac_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product_Sum stand-in: accumulates every cycle, restarts on the edge after the last pair.
  logic [15:0] acc;
  logic        last_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      last_d <= 1'b0;
    end else begin
      last_d <= mac_last;
      acc    <= (last_d ? 16'd0 : acc) + ({8'd0, mac_ai} * {8'd0, mac_xi});
    end
  end
  assign mac_result = acc;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] q_ai[$];
  logic [7:0] q_xi[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pair(input logic [7:0] ai, input logic [7:0] xi);
    u_if.wr_valid = 1'b1;
    u_if.wr_ai    = ai;
    u_if.wr_xi    = xi;
    check("wr_ready", 32'(u_if.wr_ready), 32'd1);
    tick();
    u_if.wr_valid = 1'b0;
    q_ai.push_back(ai);
    q_xi.push_back(xi);
  endtask

  task automatic run_check(input string name, input logic [15:0] exp_res);
    int n;
    n = q_ai.size();
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({name, " mac_ai"},   32'(mac_ai),   32'(q_ai[k]));
      check({name, " mac_xi"},   32'(mac_xi),   32'(q_xi[k]));
      check({name, " mac_last"}, 32'(mac_last), 32'(k == n - 1));
      check({name, " busy"},     32'(u_if.busy), 32'd1);
      tick();
    end
    check({name, " cap busy"},   32'(u_if.busy), 32'd1);
    check({name, " cap mac_ai"}, 32'(mac_ai), 32'd0);
    check({name, " cap last"},   32'(mac_last), 32'd0);
    check({name, " cap rvalid"}, 32'(u_if.result_valid), 32'd0);
    tick();
    check({name, " rvalid"},     32'(u_if.result_valid), 32'd1);
    check({name, " result"},     32'(u_if.result), 32'(exp_res));
    check({name, " busy done"},  32'(u_if.busy), 32'd0);
    $display("%s: %0d pairs, result %0h (expected %0h)", name, n, u_if.result, exp_res);
    q_ai.delete();
    q_xi.delete();
  endtask

  initial begin
    reset         = 1'b1;
    u_if.wr_valid = 1'b0;
    u_if.wr_ai    = '0;
    u_if.wr_xi    = '0;
    u_if.start    = 1'b0;
    tick();
    tick();
    check("rst busy",      32'(u_if.busy), 32'd0);
    check("rst result",    32'(u_if.result), 32'd0);
    check("rst rvalid",    32'(u_if.result_valid), 32'd0);
    check("rst mac_last",  32'(mac_last), 32'd0);
    reset = 1'b0;
    tick();
    check("idle wr_ready", 32'(u_if.wr_ready), 32'd1);

    // 1: three pairs, 6+20+42 = 68
    write_pair(8'd2, 8'd3);
    write_pair(8'd4, 8'd5);
    write_pair(8'd6, 8'd7);
    run_check("t1", 16'h0044);
    tick();
    check("t1 rvalid pulse", 32'(u_if.result_valid), 32'd0);

    // 2: full buffer, 8*65025 mod 65536 = 0xF008; ninth write refused
    for (int i = 0; i < 8; i++) write_pair(8'd255, 8'd255);
    u_if.wr_valid = 1'b1;
    u_if.wr_ai    = 8'd1;
    u_if.wr_xi    = 8'd1;
    check("t2 full wr_ready", 32'(u_if.wr_ready), 32'd0);
    tick();
    u_if.wr_valid = 1'b0;
    run_check("t2", 16'hF008);
    tick();

    // 3: start with empty buffer
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    check("t3 start_err", 32'(u_if.start_err), 32'd1);
    check("t3 busy",      32'(u_if.busy), 32'd0);
    check("t3 mac_ai",    32'(mac_ai), 32'd0);
    check("t3 mac_last",  32'(mac_last), 32'd0);
    tick();
    check("t3 err pulse", 32'(u_if.start_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3 no rvalid", 32'(u_if.result_valid), 32'd0);
      check("t3 idle busy", 32'(u_if.busy), 32'd0);
      tick();
    end
    $display("t3: empty start, start_err pulse checked");

    // 4: back-to-back runs must not contaminate each other
    for (int i = 0; i < 3; i++) write_pair(8'd1, 8'd1);
    run_check("t4a", 16'd3);
    write_pair(8'd10, 8'd10);
    run_check("t4b", 16'd100);
    tick();

    // 5: reset during streaming abandons the run
    write_pair(8'd1, 8'd2);
    write_pair(8'd3, 8'd4);
    write_pair(8'd5, 8'd6);
    write_pair(8'd7, 8'd8);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    tick();
    check("t5 streaming", 32'(u_if.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5 rst busy",     32'(u_if.busy), 32'd0);
    check("t5 rst mac_ai",   32'(mac_ai), 32'd0);
    check("t5 rst mac_xi",   32'(mac_xi), 32'd0);
    check("t5 rst mac_last", 32'(mac_last), 32'd0);
    check("t5 rst result",   32'(u_if.result), 32'd0);
    check("t5 rst rvalid",   32'(u_if.result_valid), 32'd0);
    check("t5 rst wr_ready", 32'(u_if.wr_ready), 32'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t5 no rvalid", 32'(u_if.result_valid), 32'd0);
      check("t5 idle mac",  32'(mac_ai), 32'd0);
      tick();
    end
    $display("t5: reset mid-run, outputs cleared");
    q_ai.delete();
    q_xi.delete();
    write_pair(8'd3, 8'd3);
    run_check("t5", 16'd9);
    tick();

    // 6: single zero pair
    write_pair(8'd0, 8'd0);
    run_check("t6", 16'd0);
    tick();
    check("t6 rvalid once", 32'(u_if.result_valid), 32'd0);
    tick();
    check("t6 rvalid stays", 32'(u_if.result_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
